// File: rtl/axi_read_scheduler.sv
// axi_read_scheduler: round-robin AR arbiter, slave decoder and AR/R handshake sequencer, one read outstanding
module axi_read_scheduler #(
  parameter int ADDR_W = 32,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID_M0,
  input  logic              ARVALID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  output logic              ARREADY_M0,
  output logic              ARREADY_M1,
  output logic              ARVALID_S0,
  output logic              ARVALID_S1,
  output logic              ARVALID_S2,
  input  logic              ARREADY_S0,
  input  logic              ARREADY_S1,
  input  logic              ARREADY_S2,
  input  logic              RVALID_S0,
  input  logic              RVALID_S1,
  input  logic              RVALID_S2,
  input  logic              RLAST_S0,
  input  logic              RLAST_S1,
  input  logic              RLAST_S2,
  output logic              RREADY_S0,
  output logic              RREADY_S1,
  output logic              RREADY_S2,
  output logic              RVALID_M0,
  output logic              RVALID_M1,
  output logic              RLAST_M0,
  output logic              RLAST_M1,
  input  logic              RREADY_M0,
  input  logic              RREADY_M1,
  output logic [1:0]        gnt,
  output logic [3:0]        slv_sel,
  output logic              dflt_active,
  output logic              len_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic prio;
  logic [LEN_W-1:0] len_q, beat_cnt, pick_len;
  logic [ADDR_W-17:0] hi;
  logic [3:0] pick_sel;
  logic in_addr, in_data, start, pick_m1, arv, ars_rdy, ar_hs, rv, rl, rr, beat, cnt_last, done;
  logic unused_addr;
  assign unused_addr = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};
  always_comb begin
    in_addr = state == ADDR;
    in_data = state == DATA;
    start = state == IDLE && (ARVALID_M0 || ARVALID_M1);
    pick_m1 = ARVALID_M1 && (!ARVALID_M0 || prio);
    hi = pick_m1 ? ARADDR_M1[ADDR_W-1:16] : ARADDR_M0[ADDR_W-1:16];
    pick_len = pick_m1 ? ARLEN_M1 : ARLEN_M0;
    pick_sel = hi == (ADDR_W-16)'(0) ? 4'b0001 :
               hi == (ADDR_W-16)'(1) ? 4'b0010 :
               hi == (ADDR_W-16)'(2) ? 4'b0100 : 4'b1000;
    arv = gnt[0] ? ARVALID_M0 : ARVALID_M1;
    rr = gnt[0] ? RREADY_M0 : RREADY_M1;
    cnt_last = beat_cnt == len_q;
    // slv_sel[3] is the internal default slave: always ready, always valid, last by count
    ars_rdy = |(slv_sel & {1'b1, ARREADY_S2, ARREADY_S1, ARREADY_S0});
    rv = |(slv_sel & {1'b1, RVALID_S2, RVALID_S1, RVALID_S0});
    rl = |(slv_sel & {cnt_last, RLAST_S2, RLAST_S1, RLAST_S0});
    ar_hs = in_addr && arv && ars_rdy;
    {ARVALID_S2, ARVALID_S1, ARVALID_S0} = slv_sel[2:0] & {3{in_addr && arv}};
    {ARREADY_M1, ARREADY_M0} = gnt & {2{in_addr && ars_rdy}};
    {RREADY_S2, RREADY_S1, RREADY_S0} = slv_sel[2:0] & {3{in_data && rr}};
    {RVALID_M1, RVALID_M0} = gnt & {2{in_data && rv}};
    {RLAST_M1, RLAST_M0} = gnt & {2{in_data && rl}};
    beat = in_data && rv && rr;
    done = beat && (rl || cnt_last);
    len_err = done && (rl != cnt_last);
    dflt_active = in_data && slv_sel[3];
    busy = state != IDLE;
    state_n = start ? ADDR : ar_hs ? DATA : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      gnt <= '0;
      slv_sel <= '0;
      len_q <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        gnt <= {pick_m1, !pick_m1};
        slv_sel <= pick_sel;
        len_q <= pick_len;
      end
      if (ar_hs) beat_cnt <= '0;
      if (beat) beat_cnt <= beat_cnt + LEN_W'(1);
      if (done) begin
        prio <= gnt[0];
        gnt <= '0;
        slv_sel <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axi_read_scheduler.sv
// tb_axi_read_scheduler: scoreboard bench for the AXI read scheduler
module tb_axi_read_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] arvalid_m, rready_m, arready_m, rvalid_m, rlast_m, gnt;
  logic [31:0] araddr_m0, araddr_m1;
  logic [3:0] arlen_m0, arlen_m1, slv_sel;
  logic [2:0] arready_s, rvalid_s, rlast_s, arvalid_s_o, rready_s;
  logic dflt_active, len_err, busy;
  logic [8:0] ar_q[$];
  logic [5:0] r_q[$];
  int n_chk = 0, n_fail = 0;
  axi_read_scheduler dut (
    .clk(clk), .rst(rst),
    .ARVALID_M0(arvalid_m[0]), .ARVALID_M1(arvalid_m[1]),
    .ARADDR_M0(araddr_m0), .ARADDR_M1(araddr_m1),
    .ARLEN_M0(arlen_m0), .ARLEN_M1(arlen_m1),
    .ARREADY_M0(arready_m[0]), .ARREADY_M1(arready_m[1]),
    .ARVALID_S0(arvalid_s_o[0]), .ARVALID_S1(arvalid_s_o[1]), .ARVALID_S2(arvalid_s_o[2]),
    .ARREADY_S0(arready_s[0]), .ARREADY_S1(arready_s[1]), .ARREADY_S2(arready_s[2]),
    .RVALID_S0(rvalid_s[0]), .RVALID_S1(rvalid_s[1]), .RVALID_S2(rvalid_s[2]),
    .RLAST_S0(rlast_s[0]), .RLAST_S1(rlast_s[1]), .RLAST_S2(rlast_s[2]),
    .RREADY_S0(rready_s[0]), .RREADY_S1(rready_s[1]), .RREADY_S2(rready_s[2]),
    .RVALID_M0(rvalid_m[0]), .RVALID_M1(rvalid_m[1]),
    .RLAST_M0(rlast_m[0]), .RLAST_M1(rlast_m[1]),
    .RREADY_M0(rready_m[0]), .RREADY_M1(rready_m[1]),
    .gnt(gnt), .slv_sel(slv_sel), .dflt_active(dflt_active), .len_err(len_err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic mon();
    if (!rst && |(arvalid_m & arready_m)) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 32'(1), 32'(0));
      else chk("ar_route", 32'({gnt, slv_sel, arvalid_s_o}), 32'(ar_q.pop_front()));
    end
    if (!rst && |(rvalid_m & rready_m)) begin
      if (r_q.size() == 0) chk("r_unexpected", 32'(1), 32'(0));
      else chk("r_beat", 32'({rvalid_m, rlast_m, dflt_active, len_err}), 32'(r_q.pop_front()));
    end else if (len_err) chk("len_err_stray", 32'(1), 32'(0));
  endtask
  task automatic nedge();
    @(negedge clk);
    mon();
  endtask
  task automatic pedge();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input int m, input logic [31:0] a, input int len);
    if (m == 0) begin
      araddr_m0 = a;
      arlen_m0 = 4'(len);
    end else begin
      araddr_m1 = a;
      arlen_m1 = 4'(len);
    end
    arvalid_m[m] = 1'b1;
  endtask
  task automatic push_ar(input int m, input int s);
    ar_q.push_back({(m != 0 ? 2'b10 : 2'b01), 4'(1 << s), (s == 3 ? 3'b000 : 3'(1 << s))});
  endtask
  task automatic wait_ar(input int m);
    int n = 0;
    do begin
      nedge();
      n++;
    end while (!(arready_m[m] && arvalid_m[m]) && n < 20);
    chk("ar_handshake", 32'(arready_m[m] && arvalid_m[m]), 32'(1));
  endtask
  // s = 3 means the default slave; last_at is the beat on which the slave raises RLAST
  task automatic burst(input int m, input int s, input int len, input int last_at, input int stall, input bit rereq);
    int nb;
    bit rl, cl;
    wait_ar(m);
    pedge();
    arvalid_m[m] = rereq;
    nb = (last_at < len ? last_at : len) + 1;
    for (int b = 0; b < nb; b++) begin
      cl = b == len;
      rl = s == 3 ? cl : b == last_at;
      r_q.push_back({(m != 0 ? 2'b10 : 2'b01), (m != 0 ? {rl, 1'b0} : {1'b0, rl}), s == 3, (rl | cl) && (rl != cl)});
      if (s != 3) begin
        rvalid_s[s] = 1'b1;
        rlast_s[s] = rl;
        if (b == 0 && stall > 0) begin
          rready_m[m] = 1'b0;
          repeat (stall) begin
            nedge();
            chk("bp_rready_s", 32'(rready_s[s]), 32'(0));
            chk("bp_rvalid_m", 32'(rvalid_m[m]), 32'(1));
            chk("bp_cnt", 32'(dut.beat_cnt), 32'(0));
            pedge();
          end
          rready_m[m] = 1'b1;
        end
      end
      nedge();
      pedge();
    end
    rvalid_s = '0;
    rlast_s = '0;
    chk("r_drain", 32'(r_q.size()), 32'(0));
    nedge();
    chk("busy_fall", 32'(busy), 32'(0));
    pedge();
  endtask
  function automatic logic [20:0] outs();
    return {arready_m, arvalid_s_o, rready_s, rvalid_m, rlast_m, gnt, slv_sel, dflt_active, len_err, busy};
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    arvalid_m = '0;
    rready_m = 2'b11;
    araddr_m0 = '0;
    araddr_m1 = '0;
    arlen_m0 = '0;
    arlen_m1 = '0;
    arready_s = 3'b111;
    rvalid_s = '0;
    rlast_s = '0;
    pedge();
    pedge();
    nedge();
    chk("reset_outs", 32'(outs()), 32'(0));
    pedge();
    rst = 1'b0;
    req(0, 32'h0000_0100, 1);
    req(1, 32'h0002_0200, 0);
    push_ar(0, 0);
    push_ar(1, 2);
    push_ar(0, 0);
    push_ar(1, 2);
    burst(0, 0, 1, 1, 0, 1'b1);
    burst(1, 2, 0, 0, 0, 1'b1);
    burst(0, 0, 1, 1, 0, 1'b0);
    burst(1, 2, 0, 0, 0, 1'b0);
    arready_s[1] = 1'b0;
    req(0, 32'h0001_0040, 3);
    push_ar(0, 1);
    nedge();
    chk("idle_quiet", 32'({arvalid_s_o, arready_m}), 32'(0));
    pedge();
    nedge();
    chk("addr_arvalid_s1", 32'(arvalid_s_o), 32'(3'b010));
    chk("addr_hold_ready", 32'(arready_m), 32'(0));
    pedge();
    arready_s[1] = 1'b1;
    burst(0, 1, 3, 3, 0, 1'b0);
    req(1, 32'h0002_0000, 1);
    push_ar(1, 2);
    burst(1, 2, 1, 1, 3, 1'b0);
    req(0, 32'h0005_0000, 2);
    push_ar(0, 3);
    burst(0, 3, 2, 99, 0, 1'b0);
    req(0, 32'h0000_0000, 3);
    push_ar(0, 0);
    burst(0, 0, 3, 1, 0, 1'b0);
    req(1, 32'h0001_0000, 1);
    push_ar(1, 1);
    burst(1, 1, 1, 9, 0, 1'b0);
    req(0, 32'h0002_0000, 2);
    push_ar(0, 2);
    burst(0, 2, 2, 2, 0, 1'b0);
    req(0, 32'h0000_0010, 3);
    push_ar(0, 0);
    wait_ar(0);
    pedge();
    arvalid_m = '0;
    rvalid_s[0] = 1'b1;
    r_q.push_back({2'b01, 2'b00, 1'b0, 1'b0});
    nedge();
    pedge();
    rst = 1'b1;
    nedge();
    pedge();
    rst = 1'b0;
    nedge();
    chk("midburst_reset_outs", 32'(outs()), 32'(0));
    pedge();
    rvalid_s = '0;
    req(0, 32'h0001_0000, 15);
    req(1, 32'h0002_0000, 0);
    push_ar(0, 1);
    push_ar(1, 2);
    burst(0, 1, 15, 15, 0, 1'b0);
    burst(1, 2, 0, 0, 0, 1'b0);
    chk("ar_drain", 32'(ar_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
